// File: rtl/fork_join_sched.sv
// fork_join_sched: launches up to N_BRANCH child branches, resolves
// join / join_any / join_none, resumes the parent, then drains stragglers.
module fork_join_sched #(
   parameter int N_BRANCH = 4,
   parameter int DELAY_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [N_BRANCH-1:0] branch_en,
   input  logic [DELAY_W-1:0]  post_delay,
   input  logic [N_BRANCH-1:0] done,
   output logic [N_BRANCH-1:0] launch,
   output logic                parent_go,
   output logic [N_BRANCH-1:0] pending,
   output logic [N_BRANCH-1:0] finished,
   output logic                busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_JOIN   = 3'd2;
   localparam logic [2:0] S_DELAY  = 3'd3;
   localparam logic [2:0] S_RESUME = 3'd4;
   localparam logic [2:0] S_DRAIN  = 3'd5;

   localparam logic [1:0] M_ANY  = 2'd1;
   localparam logic [1:0] M_NONE = 2'd2;

   localparam logic [DELAY_W-1:0] D_ONE = DELAY_W'(1);

   logic [2:0]          state;
   logic [1:0]          mode_q;
   logic [N_BRANCH-1:0] en_q;
   logic [DELAY_W-1:0]  delay_q;
   logic [DELAY_W-1:0]  cnt;

   logic [N_BRANCH-1:0] upd_pend;
   logic [N_BRANCH-1:0] upd_fin;
   logic                join_ok;

   // Masks after this cycle's done pulses, and the join condition on them.
   always_comb begin
      upd_pend = pending & ~done;
      upd_fin  = finished | (done & pending);
      join_ok  = 1'b0;
      case (mode_q)
         M_ANY:   join_ok = |upd_fin;
         M_NONE:  join_ok = 1'b1;
         default: join_ok = ~|upd_pend;
      endcase
      if (~|en_q)
         join_ok = 1'b1;
   end

   // Fork/join state machine, branch tracking and post-join delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mode_q   <= '0;
         en_q     <= '0;
         delay_q  <= '0;
         cnt      <= '0;
         pending  <= '0;
         finished <= '0;
      end else begin
         pending  <= upd_pend;
         finished <= upd_fin;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LAUNCH;
                  mode_q   <= mode;
                  en_q     <= branch_en;
                  delay_q  <= post_delay;
                  pending  <= branch_en;
                  finished <= '0;
               end
            end
            S_LAUNCH, S_JOIN: begin
               if (join_ok) begin
                  if (delay_q == '0) begin
                     state <= S_RESUME;
                  end else begin
                     state <= S_DELAY;
                     cnt   <= delay_q;
                  end
               end else begin
                  state <= S_JOIN;
               end
            end
            S_DELAY: begin
               cnt <= cnt - D_ONE;
               if (cnt <= D_ONE)
                  state <= S_RESUME;
            end
            S_RESUME: begin
               state <= (|upd_pend) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
               if (~|upd_pend)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign launch    = (state == S_LAUNCH) ? en_q : '0;
   assign parent_go = (state == S_RESUME);
   assign busy      = (state != S_IDLE);

endmodule
